// File: rtl/dz_pkg.sv
// rtl/dz_pkg.sv - shared encodings and 8x8 digit glyph table for the dot-matrix scanner
// Contents: color encodings, scanner FSM states, 10x8 glyph table
// (row 0 is the top row, bit 7 is the leftmost column).
package dz_pkg;

  typedef enum logic [1:0] {
    COLOR_OFF    = 2'b00,
    COLOR_RED    = 2'b01,
    COLOR_GREEN  = 2'b10,
    COLOR_YELLOW = 2'b11
  } color_e;

  // Bit positions inside a color code; yellow lights both.
  localparam int RED_BIT   = 0;
  localparam int GREEN_BIT = 1;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } state_e;

  localparam int NUM_GLYPHS = 10;

  // GLYPH_TABLE[digit][row]; first listed entry is digit 0 / row 0.
  localparam logic [0:NUM_GLYPHS-1][0:7][7:0] GLYPH_TABLE = {
    {8'h00, 8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h3C, 8'h00},  // 0
    {8'h00, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h3C, 8'h00},  // 1
    {8'h00, 8'h3C, 8'h66, 8'h0C, 8'h18, 8'h30, 8'h7E, 8'h00},  // 2
    {8'h00, 8'h3C, 8'h66, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},  // 3
    {8'h00, 8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h7E, 8'h0C, 8'h00},  // 4
    {8'h00, 8'h7E, 8'h60, 8'h7C, 8'h06, 8'h66, 8'h3C, 8'h00},  // 5
    {8'h00, 8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C, 8'h00},  // 6
    {8'h00, 8'h7E, 8'h06, 8'h0C, 8'h18, 8'h18, 8'h18, 8'h00},  // 7
    {8'h00, 8'h3C, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},  // 8
    {8'h00, 8'h3C, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00}   // 9
  };

endpackage

// File: rtl/dz_glyph_rom.sv
// rtl/dz_glyph_rom.sv - combinational glyph row lookup
// Ports: digit[3:0] glyph select (10..15 are blank), r[2:0] row index,
//        bits[7:0] column pattern for that row (bit 7 = leftmost).
module dz_glyph_rom
  import dz_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] r,
  output logic [7:0] bits
);

  always_comb begin
    bits = 8'h00;
    if (digit < 4'(NUM_GLYPHS)) begin
      bits = GLYPH_TABLE[digit][r];
    end
  end

endmodule

// File: rtl/dz_scan.sv
// rtl/dz_scan.sv - 8x8 bicolor dot-matrix digit scanner with frame-aligned reload
// Ports: clk, rst (async active-low); digit[3:0]/color[1:0]/digit_valid/ready
//        load handshake; row[7:0] active-low row drive; colr[7:0]/colg[7:0]
//        active-high red/green column drive. All outputs are registered.
module dz_scan
  import dz_pkg::*;
#(
  parameter int SCAN_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic [1:0] color,
  input  logic       digit_valid,
  output logic       ready,
  output logic [7:0] row,
  output logic [7:0] colr,
  output logic [7:0] colg
);

  localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

  state_e           state_q, state_d;
  logic [2:0]       row_idx_q, row_idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       shd_digit_q, shd_digit_d;
  logic [1:0]       shd_color_q, shd_color_d;
  logic [3:0]       pnd_digit_q, pnd_digit_d;
  logic [1:0]       pnd_color_q, pnd_color_d;
  logic             pnd_valid_q, pnd_valid_d;
  logic [7:0]       row_q, row_d;
  logic [7:0]       colr_q, colr_d;
  logic [7:0]       colg_q, colg_d;
  logic [7:0]       glyph_bits;
  logic             xfer;

  // Only a waiting pending value blocks new loads; OFF never has one.
  assign ready = ~pnd_valid_q;
  assign xfer  = digit_valid & ready;

  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    div_d       = div_q;
    shd_digit_d = shd_digit_q;
    shd_color_d = shd_color_q;
    pnd_digit_d = pnd_digit_q;
    pnd_color_d = pnd_color_q;
    pnd_valid_d = pnd_valid_q;
    case (state_q)
      ST_OFF: begin
        if (xfer) begin
          state_d     = ST_RUN;
          row_idx_d   = 3'd0;
          div_d       = '0;
          shd_digit_d = digit;
          shd_color_d = color;
        end
      end
      ST_RUN: begin
        if (div_q == DIV_LAST) begin
          div_d     = '0;
          row_idx_d = row_idx_q + 3'd1;
          // Swap only on the 7->0 wrap so a frame never mixes two glyphs.
          if (row_idx_q == 3'd7 && pnd_valid_q) begin
            shd_digit_d = pnd_digit_q;
            shd_color_d = pnd_color_q;
            pnd_valid_d = 1'b0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
        // xfer implies no pending value, so this never collides with the swap.
        if (xfer) begin
          pnd_digit_d = digit;
          pnd_color_d = color;
          pnd_valid_d = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Outputs are computed from the next row/shadow so they change on the
  // same edge as the row index.
  dz_glyph_rom u_glyph_rom (
    .digit (shd_digit_d),
    .r     (row_idx_d),
    .bits  (glyph_bits)
  );

  always_comb begin
    row_d  = 8'hFF;
    colr_d = 8'h00;
    colg_d = 8'h00;
    if (state_d == ST_RUN) begin
      row_d  = ~(8'h01 << row_idx_d);
      colr_d = shd_color_d[RED_BIT]   ? glyph_bits : 8'h00;
      colg_d = shd_color_d[GREEN_BIT] ? glyph_bits : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_OFF;
      row_idx_q   <= 3'd0;
      div_q       <= '0;
      shd_digit_q <= 4'd0;
      shd_color_q <= 2'd0;
      pnd_digit_q <= 4'd0;
      pnd_color_q <= 2'd0;
      pnd_valid_q <= 1'b0;
      row_q       <= 8'hFF;
      colr_q      <= 8'h00;
      colg_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      div_q       <= div_d;
      shd_digit_q <= shd_digit_d;
      shd_color_q <= shd_color_d;
      pnd_digit_q <= pnd_digit_d;
      pnd_color_q <= pnd_color_d;
      pnd_valid_q <= pnd_valid_d;
      row_q       <= row_d;
      colr_q      <= colr_d;
      colg_q      <= colg_d;
    end
  end

  assign row  = row_q;
  assign colr = colr_q;
  assign colg = colg_q;

endmodule

// File: doc/dz_scan.md
DZ_SCAN -- requirements
Module: dz_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1, is the number of clk cycles each row is held (legal range 1..1024).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 digit  input  4  value to display; 0..9 are legal, 10..15 display blank.
REQ-005 color  input  2  00 off, 01 red, 10 green, 11 yellow (red+green).
REQ-006 digit_valid  input  1  request to load digit/color.
REQ-007 ready  output  1  high when a new digit/color can be accepted.
REQ-008 row  output  8  row drive, active-low, one-hot-zero.
REQ-009 colr  output  8  red column drive, active-high.
REQ-010 colg  output  8  green column drive, active-high.

Function
REQ-011 The FSM SHALL have two states: OFF (nothing loaded) and RUN (scanning).
REQ-012 Transfer SHALL occur on any clock edge with digit_valid=1 and ready=1; digit_valid with ready=0 SHALL be ignored and is not queued.
REQ-013 In OFF, ready SHALL be 1. An accepted transfer SHALL load the shadow register and enter RUN at row 0 on the next edge.
REQ-014 In RUN, an accepted transfer SHALL go to a pending register and drive ready to 0 on the next edge.
REQ-015 Pending content SHALL be copied into the shadow register at the edge where the row index wraps from 7 to 0, so frames never mix digits; ready SHALL return to 1 on that same edge.
REQ-016 The divider SHALL count 0..SCAN_DIV-1; the row index SHALL advance modulo 8 when the divider equals SCAN_DIV-1, and the divider SHALL then wrap to 0.
REQ-017 When SCAN_DIV=1 the row index SHALL advance every cycle.
REQ-018 All outputs SHALL be registered, with no combinational path from any input to row, colr or colg.
REQ-019 For row index r in RUN: row = ~(8'b1 << r); colr = glyph(shadow digit, r) when color bit0=1, else 0; colg = glyph(shadow digit, r) when color bit1=1, else 0.
REQ-020 row, colr and colg SHALL update on the same edge, and that edge SHALL be the edge on which the row index changes.
REQ-021 In OFF: row=8'hFF, colr=8'h00, colg=8'h00.
REQ-022 A digit of 10..15 SHALL produce glyph rows of 8'h00 while row scanning continues normally.
REQ-023 color=00 SHALL give colr=colg=0 while scanning continues.
REQ-024 RUN SHALL never return to OFF except through reset.

Reset
REQ-025 While rst=0: state=OFF, row index=0, divider=0, shadow and pending registers cleared, ready=1, row=8'hFF, colr=8'h00, colg=8'h00.
REQ-026 Reset asserted mid-frame SHALL take effect immediately (asynchronously), and any pending transfer SHALL be discarded.
REQ-027 After rst deasserts, the block SHALL stay in OFF until the first transfer.

Structure
REQ-028 A shared package dz_pkg SHALL hold the color encodings, the FSM state encoding, and the 10x8 glyph table; the table has row 0 at the top and bit 7 as the leftmost column.
REQ-029 Digit 1 SHALL be defined as rows 00,18,38,18,18,18,3C,00 (hex).
REQ-030 A combinational sub-module dz_glyph_rom (inputs digit[3:0], r[2:0]; output bits[7:0]) SHALL hold the table lookup, including the blank output for 10..15.

Verification
REQ-031 Reset scenario: assert rst=0 for 3 cycles -> row=FF, colr=00, colg=00, ready=1; hold digit_valid=0 for 20 cycles after release -> outputs unchanged.
REQ-032 Load scenario: SCAN_DIV=1, load digit=1, color=01 -> next edge row=FE, colr=00; following edges row=FD, colr=18; then row=FB, colr=38; ... row=7F, colr=00; then the sequence repeats; colg=00 throughout.
REQ-033 Mid-frame load: while showing digit 1, load digit=1, color=10 at row index 3 -> ready=0 from the next edge; colr continues until the row 7 edge; at wrap row=FE, ready=1, and colg carries the data from then on while colr=00.
REQ-034 Busy scenario: a second digit_valid while ready=0 -> ignored; the displayed digit after wrap is the first pending value.
REQ-035 Divider scenario: SCAN_DIV=4 -> row holds each value for exactly 4 cycles; a full frame takes 32 cycles.
REQ-036 Blank digit: load digit=12, color=11 -> row keeps scanning FE..7F while colr=colg=00; then assert rst=0 mid-frame -> row=FF immediately, with no clock edge needed.
